// File: rtl/instr_mem_loadable.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_mem_loadable                                               |
// | Purpose  : Loadable instruction memory with a registered fetch port and a   |
// |            streaming valid/ready program-load engine.                       |
// |            Optional even-parity protection: define INSTR_MEM_PARITY_EN.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module instr_mem_loadable #(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        ADDR_W   = 6,
  parameter int unsigned        DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned c_PAR_W = 1;
`else
  localparam int unsigned c_PAR_W = 0;
`endif
  localparam int unsigned       c_MEM_W     = DATA_W + c_PAR_W;
  localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  generate
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("instr_mem_loadable: DEPTH must lie in 1..2**ADDR_W");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                fault_q, fault_d;
  logic                w_we;
  logic                w_in_range;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [c_MEM_W-1:0]  w_rd_word;
  logic [c_MEM_W-1:0]  w_wr_word;

  // Storage is deliberately outside the reset domain so a program survives rst_n.
  logic [c_MEM_W-1:0]  mem_q [DEPTH];

  assign w_in_range = ({1'b0, fetch_addr} < c_DEPTH_EXT);
  assign w_rd_addr  = w_in_range ? fetch_addr : '0;
  assign w_rd_word  = mem_q[w_rd_addr];

`ifdef INSTR_MEM_PARITY_EN
  logic perr_q, perr_d;
  assign w_wr_word  = {^load_data, load_data};
  assign parity_err = perr_q;
`else
  assign w_wr_word  = load_data;
`endif

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[ptr_q] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= NOP_WORD;
      fault_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fault_q <= fault_d;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    done_d     = 1'b0;
    w_we       = 1'b0;
    valid_d    = valid_q;
    data_d     = data_q;
    fault_d    = fault_q;
`ifdef INSTR_MEM_PARITY_EN
    perr_d     = perr_q;
`endif
    load_ready = (state_q == ST_LOAD);
    load_busy  = (state_q == ST_LOAD);

    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          w_we  = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          // A full array ends the load even without load_last.
          if (load_last || (ptr_q == c_LAST)) begin
            state_d = ST_RUN;
            ptr_d   = '0;
            count_d = {1'b0, ptr_q} + (ADDR_W + 1)'(1);
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    endcase

    if (!fetch_stall) begin
      if (state_q == ST_LOAD || !fetch_req) begin
        valid_d = 1'b0;
        fault_d = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
        perr_d  = 1'b0;
`endif
      end else if (w_in_range) begin
        valid_d = 1'b1;
        fault_d = 1'b0;
        data_d  = w_rd_word[DATA_W-1:0];
`ifdef INSTR_MEM_PARITY_EN
        perr_d  = ^w_rd_word;
        if (^w_rd_word) begin
          data_d = NOP_WORD;
        end
`endif
      end else begin
        valid_d = 1'b1;
        fault_d = 1'b1;
        data_d  = NOP_WORD;
`ifdef INSTR_MEM_PARITY_EN
        perr_d  = 1'b0;
`endif
      end
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_data  = data_q;
  assign fetch_fault = fault_q;
  assign load_done   = done_q;
  assign load_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_instr_mem_loadable                                            |
// | Purpose  : Directed, table-driven self-checking bench for instr_mem_loadable|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_req, fetch_stall;
  logic [5:0]  fetch_addr;
  logic        fetch_valid, fetch_fault;
  logic [15:0] fetch_data;
  logic        load_start, load_valid, load_last;
  logic [15:0] load_data;
  logic        load_ready, load_busy, load_done;
  logic [6:0]  load_count;

  logic        f48_req, f48_stall;
  logic [5:0]  f48_addr;
  logic        f48_valid, f48_fault;
  logic [15:0] f48_data;
  logic        l48_start, l48_valid, l48_last;
  logic [15:0] l48_data;
  logic        l48_ready, l48_busy, l48_done;
  logic [6:0]  l48_count;

`ifdef INSTR_MEM_PARITY_EN
  logic        parity_err, parity_err48;
`endif

  instr_mem_loadable dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .load_count(load_count)
`ifdef INSTR_MEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  instr_mem_loadable #(.DEPTH(48)) dut48 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(f48_req), .fetch_addr(f48_addr), .fetch_stall(f48_stall),
    .fetch_valid(f48_valid), .fetch_data(f48_data), .fetch_fault(f48_fault),
    .load_start(l48_start), .load_valid(l48_valid), .load_data(l48_data),
    .load_last(l48_last), .load_ready(l48_ready), .load_busy(l48_busy),
    .load_done(l48_done), .load_count(l48_count)
`ifdef INSTR_MEM_PARITY_EN
    , .parity_err(parity_err48)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [5:0]  addr;
    logic        stall;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] words[4];

  initial begin
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    vecs[0] = '{1'b1, 6'd2, 1'b0, 1'b1, 16'h3333, 1'b0};
    vecs[1] = '{1'b1, 6'd0, 1'b0, 1'b1, 16'h1111, 1'b0};
    vecs[2] = '{1'b0, 6'd3, 1'b0, 1'b0, 16'h1111, 1'b0};
    vecs[3] = '{1'b1, 6'd3, 1'b0, 1'b1, 16'h4444, 1'b0};
    vecs[4] = '{1'b1, 6'd1, 1'b1, 1'b1, 16'h4444, 1'b0};
    vecs[5] = '{1'b0, 6'd1, 1'b0, 1'b0, 16'h4444, 1'b0};
    vecs[6] = '{1'b1, 6'd1, 1'b1, 1'b0, 16'h4444, 1'b0};
    vecs[7] = '{1'b1, 6'd1, 1'b0, 1'b1, 16'h2222, 1'b0};

    rst_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    f48_req = 1'b0; f48_addr = '0; f48_stall = 1'b0;
    l48_start = 1'b0; l48_valid = 1'b0; l48_data = '0; l48_last = 1'b0;

    repeat (2) tick();
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_data",  32'(fetch_data),  32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_ready", 32'(load_ready),  32'd0);
    chk("rst_busy",  32'(load_busy),   32'd0);
    chk("rst_done",  32'(load_done),   32'd0);
    chk("rst_count", 32'(load_count),  32'd0);
    rst_n = 1'b1;
    tick();

    // Four-word program with an explicit last beat.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load4_busy",  32'(load_busy),  32'd1);
    chk("load4_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 3);
      tick();
      if (i < 3) begin
        chk($sformatf("load4_done_b%0d", i), 32'(load_done), 32'd0);
        chk($sformatf("load4_busy_b%0d", i), 32'(load_busy), 32'd1);
      end else begin
        chk("load4_done_end",  32'(load_done),  32'd1);
        chk("load4_busy_end",  32'(load_busy),  32'd0);
        chk("load4_ready_end", 32'(load_ready), 32'd0);
        chk("load4_count",     32'(load_count), 32'd4);
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    chk("load4_done_pulse", 32'(load_done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      fetch_req   = vecs[i].req;
      fetch_addr  = vecs[i].addr;
      fetch_stall = vecs[i].stall;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i),  32'(fetch_data),  32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].exp_fault));
    end

    // Stall holds outputs while a different request is presented.
    fetch_req = 1'b1; fetch_addr = 6'd0; fetch_stall = 1'b0;
    tick();
    chk("stall_pre_data", 32'(fetch_data), 32'h1111);
    fetch_addr = 6'd1; fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), 32'(fetch_valid), 32'd1);
      chk($sformatf("stall%0d_data", i),  32'(fetch_data),  32'h1111);
    end
    fetch_stall = 1'b0;
    tick();
    chk("stall_rel_data",  32'(fetch_data),  32'h2222);
    chk("stall_rel_valid", 32'(fetch_valid), 32'd1);
    fetch_req = 1'b0;

    // Out-of-range boundary on a 48-word instance.
    f48_req = 1'b1;
    f48_addr = 6'd50; tick();
    chk("d48_a50_valid", 32'(f48_valid), 32'd1);
    chk("d48_a50_data",  32'(f48_data),  32'd0);
    chk("d48_a50_fault", 32'(f48_fault), 32'd1);
    f48_addr = 6'd48; tick();
    chk("d48_a48_fault", 32'(f48_fault), 32'd1);
    f48_addr = 6'd47; tick();
    chk("d48_a47_fault", 32'(f48_fault), 32'd0);
    chk("d48_a47_valid", 32'(f48_valid), 32'd1);
    f48_addr = 6'd63; tick();
    chk("d48_a63_fault", 32'(f48_fault), 32'd1);
    chk("d48_a63_data",  32'(f48_data),  32'd0);
    f48_req = 1'b0; tick();
    chk("d48_idle_valid", 32'(f48_valid), 32'd0);
    chk("d48_idle_fault", 32'(f48_fault), 32'd0);
    chk("d48_idle_data",  32'(f48_data),  32'd0);

    // Start and fetch in the same cycle, then a forced-end 64-beat load with fetches dropped.
    fetch_req = 1'b1; fetch_addr = 6'd1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("sf_valid", 32'(fetch_valid), 32'd1);
    chk("sf_data",  32'(fetch_data),  32'h2222);
    chk("sf_busy",  32'(load_busy),   32'd1);
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hA000 + 16'(i);
      load_last  = 1'b0;
      fetch_addr = 6'(i);
      tick();
      chk($sformatf("l64_valid_b%0d", i), 32'(fetch_valid), 32'd0);
      if (i < 63) begin
        chk($sformatf("l64_done_b%0d", i), 32'(load_done), 32'd0);
      end else begin
        chk("l64_done_end",  32'(load_done),  32'd1);
        chk("l64_busy_end",  32'(load_busy),  32'd0);
        chk("l64_count",     32'(load_count), 32'd64);
      end
    end
    load_data  = 16'hFFFF;
    fetch_addr = 6'd63;
    tick();
    chk("l64_after_valid", 32'(fetch_valid), 32'd1);
    chk("l64_after_data",  32'(fetch_data),  32'hA03F);
    chk("l64_after_done",  32'(load_done),   32'd0);
    chk("l64_after_busy",  32'(load_busy),   32'd0);
    load_valid = 1'b0;
    fetch_addr = 6'd0;
    tick();
    chk("l64_mem0", 32'(fetch_data), 32'hA000);
    fetch_req = 1'b0;

    // Reset mid-load; a second load_start in LOAD must not restart the pointer.
    load_start = 1'b1; tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'h5A5A; tick();
    load_start = 1'b1; load_data = 16'hC3C3; tick();
    load_start = 1'b0; load_valid = 1'b0;
    chk("rl_busy_pre", 32'(load_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rl_busy",  32'(load_busy),  32'd0);
    chk("rl_ready", 32'(load_ready), 32'd0);
    chk("rl_count", 32'(load_count), 32'd0);
    chk("rl_done",  32'(load_done),  32'd0);
    tick();
    chk("rl_done_hold", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rl_done_rel", 32'(load_done), 32'd0);
    fetch_req = 1'b1;
    fetch_addr = 6'd0; tick();
    chk("rl_mem0", 32'(fetch_data), 32'h5A5A);
    fetch_addr = 6'd1; tick();
    chk("rl_mem1", 32'(fetch_data), 32'hC3C3);
    fetch_addr = 6'd2; tick();
    chk("rl_mem2", 32'(fetch_data), 32'hA002);
    fetch_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, synchronous, loadable instruction memory for the RISC processor.
- Replaces the fixed 64x16 combinational instruction ROM.
- Fetch port: one-cycle registered read with stall hold and out-of-range fault.
- Load port: a streaming valid/ready program-load engine, so programs are written at run time instead of being hard-coded.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 6, fetch address width in bits.
- DEPTH, 64, number of implemented words; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- NOP_WORD, 0 (DATA_W bits), word returned on a faulting fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  word address to fetch.
- fetch_stall  in  1  pipeline stall; hold all fetch outputs.
- fetch_valid  out  1  fetch_data is valid.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_fault  out  1  the fetched address was >= DEPTH.
- load_start  in  1  begin a program load at word 0.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  program word to write.
- load_last  in  1  this load beat is the final word.
- load_ready  out  1  load engine accepts a beat.
- load_busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  number of words written by the last load.

Behaviour:
- Clocking and reset
  - Single clock domain, clk.
  - rst_n is asynchronous and active-low.
  - Reset values: fetch_valid=0, fetch_data=NOP_WORD, fetch_fault=0, load_ready=0, load_busy=0, load_done=0, load_count=0, state=RUN, load pointer=0.
  - The memory array is not reset; its contents survive rst_n.
- State machine: two states, RUN and LOAD.
  - RUN -> LOAD: on load_start=1. The pointer is cleared to 0, and load_busy and load_ready rise the next cycle.
  - LOAD: load_ready=1 and load_busy=1.
  - LOAD beat: on load_valid=1, mem[ptr] <= load_data and ptr increments.
  - LOAD -> RUN: on an accepted beat with load_last=1, or on an accepted beat with ptr==DEPTH-1 (forced end).
  - On exit: load_count <= ptr+1, load_done pulses for exactly 1 cycle, and load_ready and load_busy fall in the same cycle load_done rises.
  - load_start while in LOAD is ignored; the pointer is not restarted.
  - load_valid while in RUN is ignored; no write occurs.
- Fetch path (RUN only)
  - Latency is 1 cycle: fetch_req at edge N gives fetch_valid/fetch_data at edge N+1.
  - fetch_addr < DEPTH: fetch_data = mem[fetch_addr], fetch_fault = 0.
  - fetch_addr >= DEPTH: fetch_data = NOP_WORD, fetch_fault = 1, fetch_valid = 1.
  - fetch_req=0 with no stall: fetch_valid=0 and fetch_fault=0 next cycle; fetch_data holds its last value.
  - fetch_stall=1: fetch_valid, fetch_data and fetch_fault hold, and fetch_req is ignored. Stall takes priority over req.
- Fetch/load interaction
  - In LOAD, fetch_valid is forced 0 and fetch requests are dropped, not queued.
  - load_start and fetch_req in the same RUN cycle: the fetch is serviced from the pre-load contents, and LOAD begins next cycle.
  - A fetch issued in the cycle after load_done returns the newly loaded data; there is no write-to-read hazard because the last write has already completed.
- Reset during LOAD
  - FSM returns to RUN, pointer=0, load_count=0, and load_done is not pulsed.
  - Words already written remain in the array.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit, computed on load.
  - The parity is checked on every in-range fetch.
  - Added output parity_err (out, 1): registered and aligned with fetch_valid; 1 when the stored parity mismatches.
  - On a parity error, fetch_data is replaced by NOP_WORD, and fetch_fault remains 0.
  - parity_err resets to 0 and holds under stall like the other fetch outputs.
- When undefined: no parity storage, no parity_err port, and behaviour exactly as above.

Test Plan:
- Reset, then load_start, then 4 beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 with load_last on beat 4 -> load_done pulses once, load_count=4, load_busy falls. Then fetch addr 2 -> next cycle fetch_valid=1, fetch_data=16'h3333, fetch_fault=0.
- DEPTH=48: fetch addr 50 -> fetch_valid=1, fetch_data=16'h0000, fetch_fault=1.
- Fetch addr 0 (16'h1111), stall asserted for 3 cycles while fetch_req=1 and addr=1 -> outputs hold 16'h1111 and valid=1. Release stall -> 16'h2222 one cycle later.
- Load 64 beats without load_last (DEPTH=64) -> forced end after beat 64, load_count=64. A 65th load_valid is ignored and mem[0] is unchanged.
- fetch_req during LOAD -> fetch_valid stays 0 throughout. load_start and fetch_req at addr 1 in the same RUN cycle -> old word returned, then load_busy=1.
- Assert rst_n=0 after 2 load beats -> state RUN, load_count=0, no load_done. Fetch addr 0 and 1 -> the 2 written words are still returned.
